// File: rtl/switch_allocator.sv
// Wormhole switch allocator for the 5-port mesh router: per-output round-robin head-to-tail locking.
// Define SA_DROP_CNT_EN to add the saturating drop_cnt port.
module switch_allocator #(
  parameter int unsigned IDLE_TIMEOUT = 0,
  parameter int unsigned TO_W         = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  req_valid,
  input  logic [9:0]  flit_type,
  input  logic [14:0] route_sel,
  input  logic [4:0]  out_ready,
  output logic [4:0]  grant,
  output logic [4:0]  out_valid,
  output logic [14:0] xbar_sel
`ifdef SA_DROP_CNT_EN
  ,
  output logic [7:0]  drop_cnt
`endif
);

  localparam int unsigned NP = 5;
  localparam int unsigned SW = 3;
  localparam int unsigned EW = 4;
  localparam logic [SW-1:0] SEL_NONE = 3'b111;
  localparam logic [SW-1:0] MAX_PORT = 3'd4;
  localparam logic [1:0]    FT_HEAD  = 2'b11;
  localparam logic [1:0]    FT_TAIL  = 2'b10;

  typedef enum logic [1:0] {IN_IDLE, IN_ROUTED, IN_DROP} in_state_e;

  in_state_e               in_state_q [NP];
  in_state_e               in_state_d [NP];
  logic [NP-1:0][SW-1:0]   sel_q, sel_d;
  logic [NP-1:0][SW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [NP-1:0][TO_W-1:0] to_cnt_q, to_cnt_d;
  logic [EW-1:0]           drop_evt;

  // The per-output select register doubles as the lock owner; SEL_NONE means free.
  assign xbar_sel = sel_q;

  // Next-state and combinational grant/out_valid.
  always_comb begin
    int w;
    int c;
    logic found;
    logic [1:0] ft;
    logic [SW-1:0] rs;
    w          = 0;
    c          = 0;
    found      = 1'b0;
    ft         = '0;
    rs         = '0;
    grant      = '0;
    out_valid  = '0;
    drop_evt   = '0;
    in_state_d = in_state_q;
    sel_d      = sel_q;
    rr_ptr_d   = rr_ptr_q;
    to_cnt_d   = to_cnt_q;

    // Locked outputs forward the owner's flits; tail or idle timeout releases the lock.
    for (int o = 0; o < NP; o++) begin
      if (sel_q[o] != SEL_NONE) begin
        w            = int'(sel_q[o]);
        out_valid[o] = req_valid[w];
        grant[w]     = req_valid[w] & out_ready[o];
        if (grant[w] && flit_type[2*w +: 2] == FT_TAIL) begin
          sel_d[o]      = SEL_NONE;
          in_state_d[w] = IN_IDLE;
          to_cnt_d[o]   = '0;
        end else if (IDLE_TIMEOUT != 0) begin
          if (req_valid[w]) begin
            to_cnt_d[o] = '0;
          end else if (to_cnt_q[o] + TO_W'(1) == TO_W'(IDLE_TIMEOUT)) begin
            sel_d[o]      = SEL_NONE;
            in_state_d[w] = IN_DROP;
            to_cnt_d[o]   = '0;
            drop_evt      = drop_evt + EW'(1);
          end else begin
            to_cnt_d[o] = to_cnt_q[o] + TO_W'(1);
          end
        end
      end
    end

    // Inputs not holding an output: discard strays, bad heads and dropped packets.
    for (int i = 0; i < NP; i++) begin
      ft = flit_type[2*i +: 2];
      rs = route_sel[3*i +: 3];
      if (req_valid[i]) begin
        case (in_state_q[i])
          IN_IDLE: begin
            if (ft != FT_HEAD) begin
              grant[i] = 1'b1;
              drop_evt = drop_evt + EW'(1);
            end else if (rs > MAX_PORT || rs == SW'(i)) begin
              grant[i]      = 1'b1;
              in_state_d[i] = IN_DROP;
              drop_evt      = drop_evt + EW'(1);
            end
          end
          IN_DROP: begin
            grant[i] = 1'b1;
            if (ft == FT_TAIL) in_state_d[i] = IN_IDLE;
          end
          default: ;
        endcase
      end
    end

    // Round-robin arbitration on free outputs; the winning head is granted next cycle.
    for (int o = 0; o < NP; o++) begin
      if (sel_q[o] == SEL_NONE) begin
        found = 1'b0;
        for (int k = 0; k < NP; k++) begin
          c = (int'(rr_ptr_q[o]) + k) % int'(NP);
          if (!found && req_valid[c] && in_state_q[c] == IN_IDLE &&
              flit_type[2*c +: 2] == FT_HEAD && route_sel[3*c +: 3] == SW'(o) && c != o) begin
            found         = 1'b1;
            sel_d[o]      = SW'(c);
            rr_ptr_d[o]   = SW'((c + 1) % int'(NP));
            in_state_d[c] = IN_ROUTED;
            to_cnt_d[o]   = '0;
          end
        end
      end
    end

    if (!reset) begin
      grant     = '0;
      out_valid = '0;
    end
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NP; i++) in_state_q[i] <= IN_IDLE;
      sel_q    <= '1;
      rr_ptr_q <= '0;
      to_cnt_q <= '0;
    end else begin
      in_state_q <= in_state_d;
      sel_q      <= sel_d;
      rr_ptr_q   <= rr_ptr_d;
      to_cnt_q   <= to_cnt_d;
    end
  end

`ifdef SA_DROP_CNT_EN
  logic [8:0] drop_sum;
  assign drop_sum = 9'(drop_cnt) + 9'(drop_evt);

  // Saturating drop event counter.
  always_ff @(posedge clk) begin
    if (!reset) drop_cnt <= '0;
    else        drop_cnt <= (drop_sum > 9'd255) ? 8'hFF : drop_sum[7:0];
  end
`else
  logic unused_drop_evt;
  assign unused_drop_evt = ^drop_evt;
`endif

endmodule

// File: tb/tb_switch_allocator.sv
// Randomized scoreboard bench for switch_allocator against a packet-level reference model.
module tb_switch_allocator;

  localparam int NP     = 5;
  localparam int TMO    = 4;
  localparam int N_RAND = 3000;
  localparam int RST_A  = 1700;
  localparam int RST_B  = 2600;

  logic        clk;
  logic        reset;
  logic [4:0]  req_valid;
  logic [9:0]  flit_type;
  logic [14:0] route_sel;
  logic [4:0]  out_ready;
  logic [4:0]  grant;
  logic [4:0]  out_valid;
  logic [14:0] xbar_sel;
`ifdef SA_DROP_CNT_EN
  logic [7:0]  drop_cnt;
`endif

  switch_allocator #(.IDLE_TIMEOUT(TMO), .TO_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .flit_type (flit_type),
    .route_sel (route_sel),
    .out_ready (out_ready),
    .grant     (grant),
    .out_valid (out_valid),
    .xbar_sel  (xbar_sel)
`ifdef SA_DROP_CNT_EN
    ,
    .drop_cnt  (drop_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  g;
    logic [4:0]  ov;
    logic [14:0] sel;
    logic [7:0]  dc;
  } exp_t;

  exp_t expq[$];
  int   checks;
  int   failures;

  // Reference model: input mode 0 idle, 1 holding output m_dest, 2 discarding until tail.
  int m_mode [NP];
  int m_dest [NP];
  int m_idle [NP];
  int m_rr   [NP];
  int m_drops;

  // Traffic sources: one packet buffer per input, flit = {type[1:0], route[2:0]}.
  logic [4:0] pkt [NP][8];
  int plen  [NP];
  int ppos  [NP];
  bit shown [NP];
  int gap   [NP];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NP; i++) begin
      m_mode[i] = 0;
      m_dest[i] = 0;
      m_idle[i] = 0;
      m_rr[i]   = 0;
    end
    m_drops = 0;
  endtask

  function automatic logic [14:0] model_sel();
    logic [14:0] s;
    s = 15'h7FFF;
    for (int i = 0; i < NP; i++)
      if (m_mode[i] == 1) s[3*m_dest[i] +: 3] = 3'(i);
    return s;
  endfunction

  task automatic model_cycle(input logic [4:0] v, input logic [9:0] ft, input logic [14:0] rs,
                             input logic [4:0] rdy, input bit rst_now,
                             output logic [4:0] g, output logic [4:0] ov);
    int nmode [NP];
    int ndest [NP];
    int nidle [NP];
    bit busy  [NP];
    int ev, best, bestd, d, typ, rt;
    g  = '0;
    ov = '0;
    if (rst_now) begin
      model_reset();
    end else begin
      nmode = m_mode;
      ndest = m_dest;
      nidle = m_idle;
      ev    = 0;
      for (int o = 0; o < NP; o++) busy[o] = 1'b0;
      for (int i = 0; i < NP; i++) if (m_mode[i] == 1) busy[m_dest[i]] = 1'b1;
      for (int i = 0; i < NP; i++) begin
        typ = int'(ft[2*i +: 2]);
        rt  = int'(rs[3*i +: 3]);
        if (m_mode[i] == 1) begin
          ov[m_dest[i]] = v[i];
          if (v[i]) begin
            nidle[i] = 0;
            if (rdy[m_dest[i]]) begin
              g[i] = 1'b1;
              if (typ == 2) nmode[i] = 0;
            end
          end else begin
            nidle[i] = m_idle[i] + 1;
            if (TMO > 0 && nidle[i] == TMO) begin
              nmode[i] = 2;
              ev++;
            end
          end
        end else if (m_mode[i] == 2) begin
          if (v[i]) begin
            g[i] = 1'b1;
            if (typ == 2) nmode[i] = 0;
          end
        end else if (v[i] && (typ != 3 || rt > 4 || rt == i)) begin
          g[i] = 1'b1;
          ev++;
          if (typ == 3) nmode[i] = 2;
        end
      end
      // Winner is the contender closest at or after the round-robin pointer.
      for (int o = 0; o < NP; o++) begin
        if (!busy[o]) begin
          best  = -1;
          bestd = NP;
          for (int i = 0; i < NP; i++) begin
            if (m_mode[i] == 0 && v[i] && int'(ft[2*i +: 2]) == 3 &&
                int'(rs[3*i +: 3]) == o && i != o) begin
              d = (i - m_rr[o] + NP) % NP;
              if (d < bestd) begin
                bestd = d;
                best  = i;
              end
            end
          end
          if (best >= 0) begin
            nmode[best] = 1;
            ndest[best] = o;
            nidle[best] = 0;
            m_rr[o]     = (best + 1) % NP;
          end
        end
      end
      m_mode  = nmode;
      m_dest  = ndest;
      m_idle  = nidle;
      m_drops = (m_drops + ev > 255) ? 255 : m_drops + ev;
    end
  endtask

  task automatic gen_pkt(input int i);
    int r, nb, n;
    r = int'($urandom_range(99, 0));
    if (r < 5) begin
      pkt[i][0] = {2'b01, 3'($urandom)};
      n = 1;
    end else begin
      pkt[i][0] = {2'b11, ($urandom_range(99, 0) < 15) ? 3'($urandom_range(7, 5))
                                                       : 3'($urandom_range(4, 0))};
      nb = int'($urandom_range(3, 0));
      for (int b = 0; b < nb; b++)
        pkt[i][1+b] = {($urandom_range(1, 0) == 1) ? 2'b01 : 2'b00, 3'($urandom)};
      n = 1 + nb;
      if (r >= 10) begin
        pkt[i][n] = {2'b10, 3'($urandom)};
        n++;
      end
    end
    plen[i] = n;
    ppos[i] = 0;
  endtask

  task automatic load_pkt(input int i, input logic [2:0] route, input int nb);
    pkt[i][0] = {2'b11, route};
    for (int b = 0; b < nb; b++) pkt[i][1+b] = {2'b01, 3'd0};
    pkt[i][nb+1] = {2'b10, 3'd0};
    plen[i] = nb + 2;
    ppos[i] = 0;
  endtask

  // One cycle of stimulus: drive inputs, predict outputs, queue expectation.
  task automatic step(input bit rnd, input bit rst_now);
    logic [4:0]  v, rdy, g, ov, f;
    logic [9:0]  ft;
    logic [14:0] rs;
    exp_t        e;
    for (int i = 0; i < NP; i++) begin
      if (rnd && ppos[i] >= plen[i] && $urandom_range(3, 0) == 0) gen_pkt(i);
      ft[2*i +: 2] = 2'($urandom);
      rs[3*i +: 3] = 3'($urandom);
      v[i] = 1'b0;
      if (ppos[i] < plen[i]) begin
        f = pkt[i][ppos[i]];
        if (!rnd)                             v[i] = 1'b1;
        else if (shown[i] && f[4:3] == 2'b11) v[i] = 1'b1;
        else if (gap[i] > 0)                  gap[i]--;
        else if ($urandom_range(99, 0) < 3)   gap[i] = int'($urandom_range(7, 4));
        else                                  v[i] = ($urandom_range(4, 0) != 0);
        if (v[i]) begin
          ft[2*i +: 2] = f[4:3];
          rs[3*i +: 3] = f[2:0];
        end
      end
      rdy[i] = rnd ? ($urandom_range(3, 0) != 0) : 1'b1;
    end
    reset     = ~rst_now;
    req_valid = v;
    flit_type = ft;
    route_sel = rs;
    out_ready = rdy;
    e.sel = model_sel();
    e.dc  = 8'(m_drops);
    model_cycle(v, ft, rs, rdy, rst_now, g, ov);
    e.g  = g;
    e.ov = ov;
    expq.push_back(e);
    for (int i = 0; i < NP; i++) begin
      if (g[i]) ppos[i]++;
      shown[i] = v[i] && !g[i];
    end
  endtask

  task automatic run(input int n, input bit rnd);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      step(rnd, 1'b0);
    end
  endtask

  // Monitor: compare DUT outputs against the queued expectation each cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (expq.size() != 0) begin
        e = expq.pop_front();
        check("grant", 32'(grant), 32'(e.g));
        check("out_valid", 32'(out_valid), 32'(e.ov));
        check("xbar_sel", 32'(xbar_sel), 32'(e.sel));
`ifdef SA_DROP_CNT_EN
        check("drop_cnt", 32'(drop_cnt), 32'(e.dc));
`endif
      end
    end
  end

  initial begin
    checks    = 0;
    failures  = 0;
    reset     = 1'b0;
    req_valid = '0;
    flit_type = '0;
    route_sel = '0;
    out_ready = '0;
    model_reset();
    for (int i = 0; i < NP; i++) begin
      plen[i]  = 0;
      ppos[i]  = 0;
      shown[i] = 1'b0;
      gap[i]   = 0;
    end
    repeat (3) @(negedge clk);

    load_pkt(4, 3'd2, 1);
    run(6, 1'b0);
    load_pkt(0, 3'd4, 1);
    load_pkt(1, 3'd4, 1);
    run(12, 1'b0);
    load_pkt(0, 3'd4, 1);
    load_pkt(1, 3'd4, 1);
    run(12, 1'b0);
    load_pkt(3, 3'd7, 2);
    run(8, 1'b0);
    load_pkt(2, 3'd0, 4);
    run(3, 1'b0);
    @(negedge clk);
    step(1'b0, 1'b1);
    run(8, 1'b0);

    for (int c = 0; c < N_RAND; c++) begin
      @(negedge clk);
      step(1'b1, (c == RST_A) || (c == RST_B));
    end
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
